// File: rtl/vme_dac_spi_ctrl_pkg.sv
// vme_dac_pkg: register map, status bit positions, shifter state encoding and FIFO depth for the DAC SPI controller
package vme_dac_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam int ST_BUSY    = 0;
   localparam int ST_OVR     = 1;
   localparam int ST_LVL_LSB = 8;
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_SHIFT_HI = 3'd2;
   localparam logic [2:0] S_SHIFT_LO = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;
   localparam logic [2:0] S_GAP      = 3'd5;
   localparam int FIFO_DEPTH = 4;
endpackage

// File: rtl/vme_dac_spi_ctrl_if.sv
// vme_dac_spi_ctrl_if: Wishbone classic-cycle signals between the VME64x master port and the DAC controller
interface vme_dac_spi_ctrl_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [1:0]  adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;
   modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
   modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
endinterface

// File: rtl/vme_dac_spi_ctrl_shifter.sv
// dac_spi_shifter: sequences one MSB-first SPI frame (setup, NBITS low/high sck pairs, hold, inter-frame gap)
module dac_spi_shifter
   import vme_dac_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int NBITS   = 24
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [NBITS-1:0] word_i,
   output logic             busy_o,
   output logic             rdy_o,
   output logic             sck_o,
   output logic             sdo_o,
   output logic             cs_n_o
);
   localparam logic [7:0] DIV_RLD = 8'(CLK_DIV - 1);
   localparam logic [5:0] BIT_RLD = 6'(NBITS);
   logic [2:0]       state_q, state_d;
   logic [7:0]       div_q, div_d;
   logic [5:0]       bit_q, bit_d;
   logic [NBITS-1:0] sh_q, sh_d;
   logic             phase_end, gap_end, load, lo_end;

   assign phase_end = div_q == 8'd0;
   assign gap_end   = state_q == S_GAP && phase_end && bit_q == 6'd0;
   assign rdy_o     = state_q == S_IDLE || gap_end;
   assign load      = state_d == S_SETUP && state_q != S_SETUP;
   assign lo_end    = state_q == S_SHIFT_LO && phase_end;

   // state, counters and shift register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   // next state: every timed phase ends when the half-period counter hits zero
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start_i) state_d = S_SETUP;
         S_SETUP:    if (phase_end) state_d = S_SHIFT_LO;
         S_SHIFT_LO: if (phase_end) state_d = S_SHIFT_HI;
         S_SHIFT_HI: if (phase_end) state_d = bit_q == 6'd0 ? S_HOLD : S_SHIFT_LO;
         S_HOLD:     if (phase_end) state_d = S_GAP;
         S_GAP:      if (gap_end) state_d = start_i ? S_SETUP : S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // counters: bit_q counts low phases down, then is reused as the two-half-period gap count
   always_comb begin
      div_d = (state_d != state_q || phase_end || state_q == S_IDLE) ? DIV_RLD : div_q - 8'd1;
      bit_d = load ? BIT_RLD :
              lo_end ? bit_q - 6'd1 :
              (state_q == S_HOLD && phase_end) ? 6'd1 :
              (state_q == S_GAP && phase_end && bit_q != 6'd0) ? bit_q - 6'd1 : bit_q;
      sh_d  = load ? word_i : lo_end ? {sh_q[NBITS-2:0], 1'b0} : sh_q;
   end

   // pin outputs decoded from the registered state; sdo is forced low while deselected
   always_comb begin
      busy_o = state_q != S_IDLE;
      sck_o  = state_q != S_SHIFT_LO;
      cs_n_o = state_q == S_IDLE || state_q == S_GAP;
      sdo_o  = cs_n_o ? 1'b0 : sh_q[NBITS-1];
   end
endmodule

// File: rtl/vme_dac_spi_ctrl.sv
// vme_dac_spi_ctrl: Wishbone slave front end for the bias DAC shifter; define DAC_SPI_QUEUE_EN for a 4-deep write FIFO
module vme_dac_spi_ctrl
   import vme_dac_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int NBITS   = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   vme_dac_spi_ctrl_if.slave wb,
   output logic              dac_sck_o,
   output logic              dac_sdo_o,
   output logic              dac_cs_n_o
);
   logic             ack_q, ack_d, ovr_q, ovr_d;
   logic [31:0]      dat_q, dat_d, stat, rdata;
   logic [NBITS-1:0] data_q, data_d, word;
   logic [7:0]       level;
   logic             req, com, wr_data, rd_stat, start, drop, accept, busy, sh_busy, sh_rdy;

   assign req     = wb.cyc_i & wb.stb_i;
   assign com     = req & ack_q;
   assign wr_data = com & wb.we_i & (wb.adr_i == REG_DATA);
   assign rd_stat = com & ~wb.we_i & (wb.adr_i == REG_STATUS);

`ifdef DAC_SPI_QUEUE_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [NBITS-1:0] fifo_q [FIFO_DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      cnt_q;
   logic             direct, push, pop;

   assign pop    = cnt_q != '0 && sh_rdy;
   assign direct = wr_data && sh_rdy && cnt_q == '0;
   assign push   = wr_data && !direct && cnt_q != (AW+1)'(FIFO_DEPTH);
   assign drop   = wr_data && !direct && !push;
   assign start  = direct || pop;
   assign accept = direct || push;
   assign word   = pop ? fifo_q[rd_q] : wb.dat_i[NBITS-1:0];
   assign busy   = sh_busy || cnt_q != '0;
   assign level  = 8'(cnt_q);

   // FIFO pointers and occupancy; reset flushes the queue
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(push);
         rd_q  <= rd_q + AW'(pop);
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // FIFO storage, written only on push
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_q] <= wb.dat_i[NBITS-1:0];
   end
`else
   assign start  = wr_data && sh_rdy && !sh_busy;
   assign drop   = wr_data && !start;
   assign accept = start;
   assign word   = wb.dat_i[NBITS-1:0];
   assign busy   = sh_busy;
   assign level  = '0;
`endif

   // register decode: single-cycle ack, read data latched with the ack, writes and read-clear commit in the ack cycle
   always_comb begin
      stat                    = '0;
      stat[ST_BUSY]           = busy;
      stat[ST_OVR]            = ovr_q;
      stat[ST_LVL_LSB +: 8]   = level;
      rdata  = wb.adr_i == REG_DATA ? 32'(data_q) : wb.adr_i == REG_STATUS ? stat : '0;
      ack_d  = req & ~ack_q;
      dat_d  = (ack_d && !wb.we_i) ? rdata : '0;
      ovr_d  = drop | (ovr_q & ~rd_stat);
      data_d = accept ? wb.dat_i[NBITS-1:0] : data_q;
   end

   // bus-side registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         ovr_q  <= 1'b0;
         data_q <= '0;
      end else begin
         ack_q  <= ack_d;
         dat_q  <= dat_d;
         ovr_q  <= ovr_d;
         data_q <= data_d;
      end
   end

   assign wb.ack_o = ack_q;
   assign wb.dat_o = dat_q;

   dac_spi_shifter #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) u_shifter (
      .clk_i,
      .rst_i,
      .start_i (start),
      .word_i  (word),
      .busy_o  (sh_busy),
      .rdy_o   (sh_rdy),
      .sck_o   (dac_sck_o),
      .sdo_o   (dac_sdo_o),
      .cs_n_o  (dac_cs_n_o)
   );
endmodule

// File: tb/tb_vme_dac_spi_ctrl.sv
// tb_vme_dac_spi_ctrl: directed self-checking bench for vme_dac_spi_ctrl (default build or DAC_SPI_QUEUE_EN)
module tb_vme_dac_spi_ctrl;
   import vme_dac_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   logic sck, sdo, cs_n;
   int   n_tests = 0, n_fail = 0;
   logic prev_sck = 1'b1, prev_cs = 1'b1;
   logic [31:0] rx = '0;
   int   n_fall = 0, n_cslo = 0, n_csf = 0, hi_run = 0, gap_len = 0;
   int   base_f, base_lo, base_csf;

   vme_dac_spi_ctrl_if wb();

   vme_dac_spi_ctrl #(.CLK_DIV(4), .NBITS(24)) dut (
      .clk_i(clk), .rst_i(rst), .wb(wb),
      .dac_sck_o(sck), .dac_sdo_o(sdo), .dac_cs_n_o(cs_n)
   );

   always #5 clk = ~clk;

   // pin monitor: capture sdo on falling sck while selected, count cs activity
   always @(negedge clk) begin
      if (prev_sck && !sck && !cs_n) begin
         rx     <= {rx[30:0], sdo};
         n_fall <= n_fall + 1;
      end
      if (!cs_n) n_cslo <= n_cslo + 1;
      if (prev_cs && !cs_n) begin
         n_csf   <= n_csf + 1;
         gap_len <= hi_run;
      end
      hi_run   <= cs_n ? hi_run + 1 : 0;
      prev_sck <= sck;
      prev_cs  <= cs_n;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd, output logic [31:0] rd);
      int lat = 0;
      wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we; wb.adr_i = a; wb.dat_i = wd;
      do begin @(posedge clk); #1; lat++; end while (!wb.ack_o && lat < 8);
      rd = wb.dat_o;
      chk("ack_latency", lat, 1);
      @(posedge clk); #1;
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] x;
      wb_xfer(1'b1, a, d, x);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] x;
      wb_xfer(1'b0, a, 32'h0, x);
      chk(tag, x, exp);
   endtask

   task automatic wait_falls(input int target);
      int g = 0;
      while (n_fall < target && g < 2000) begin @(negedge clk); g++; end
      chk("falls_reached", 32'(n_fall >= target), 1);
   endtask

   task automatic wait_csf(input int target);
      int g = 0;
      while (n_csf < target && g < 2000) begin @(negedge clk); g++; end
      chk("frame_started", 32'(n_csf >= target), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w [6];
      w = '{32'h00A5C3F1, 32'h00123456, 32'h00FEDCBA, 32'h00800001, 32'h0055AA55, 32'h00777777};
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0; wb.adr_i = '0; wb.dat_i = '0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_ack", wb.ack_o, 0);
      chk("rst_dat", wb.dat_o, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sck", sck, 1);
      chk("rst_sdo", sdo, 0);
      rst = 1'b0;
      rd(REG_STATUS, 32'h0, "status_after_reset");

      base_f = n_fall; base_lo = n_cslo;
      wr(REG_DATA, 32'h00A5C3F1);
      chk("start_cs_n", cs_n, 0);
      chk("start_sck", sck, 1);
      chk("start_sdo_msb", sdo, 1);
      tick(207);
      rd(REG_STATUS, 32'h1, "busy_last_cycle");
      tick(5);
      chk("f1_falls", n_fall - base_f, 24);
      chk("f1_bits", {8'h0, rx[23:0]}, 32'h00A5C3F1);
      chk("f1_cs_low", n_cslo - base_lo, 200);
      rd(REG_DATA, 32'h00A5C3F1, "data_readback");
      wr(2'd3, 32'hFFFFFFFF);
      chk("adr3_no_frame", cs_n, 1);
      rd(2'd3, 32'h0, "adr3_read");
      rd(REG_DATA, 32'h00A5C3F1, "data_after_adr3");

`ifndef DAC_SPI_QUEUE_EN
      base_f = n_fall;
      wr(REG_DATA, 32'h00C0FFEE);
      tick(10);
      wr(REG_DATA, 32'h00123456);
      tick(196);
      rd(REG_STATUS, 32'h2, "overrun_after_frame");
      rd(REG_STATUS, 32'h0, "overrun_cleared");
      rd(REG_DATA, 32'h00C0FFEE, "dropped_not_latched");
      chk("drop_falls", n_fall - base_f, 24);
      chk("drop_bits", {8'h0, rx[23:0]}, 32'h00C0FFEE);
`else
      base_f = n_fall; base_csf = n_csf;
      for (int i = 0; i < 6; i++) wr(REG_DATA, w[i]);
      rd(REG_STATUS, 32'h0403, "q_full_overrun");
      rd(REG_STATUS, 32'h0401, "q_level_4");
      for (int k = 2; k <= 5; k++) begin
         wait_csf(base_csf + k);
         chk("q_prev_frame_bits", {8'h0, rx[23:0]}, w[k-2]);
         chk("q_gap_len", gap_len, 8);
         tick(20);
         rd(REG_STATUS, 32'((5 - k) << 8) | 32'h1, "q_level");
      end
      tick(220);
      rd(REG_STATUS, 32'h0, "q_drained");
      chk("q_frames", n_csf - base_csf, 5);
      chk("q_falls", n_fall - base_f, 120);
      chk("q_last_bits", {8'h0, rx[23:0]}, w[4]);
`endif

      base_f = n_fall;
      wr(REG_DATA, 32'hFF123456);
      wait_falls(base_f + 12);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_cs_n", cs_n, 1);
      chk("midrst_sck", sck, 1);
      chk("midrst_sdo", sdo, 0);
      rst = 1'b0;
      rd(REG_STATUS, 32'h0, "midrst_status");
      base_f = n_fall;
      wr(REG_DATA, 32'h000F0F5A);
      tick(215);
      chk("fresh_falls", n_fall - base_f, 24);
      chk("fresh_bits", {8'h0, rx[23:0]}, 32'h000F0F5A);
      wr(REG_DATA, 32'hFF123456);
      rd(REG_DATA, 32'h00123456, "data_masked");
      tick(215);

      wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("ack_alternate", wb.ack_o, 32'(i % 2 == 0));
         if (wb.ack_o) chk("adr2_read", wb.dat_o, 0);
      end
      wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
      tick(2);
      chk("ack_idle", wb.ack_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
